commit_trace_buffer: RTL and testbench
======================================

// Module: commit_trace_buffer
// PURPOSE
// - Sits downstream of the cpu top and consumes its retirement port (commit, commit_pc, commit_pre_pc).
// - Time-stamps each retired instruction, sequence-numbers it and queues it in a FIFO.
// - A debug/difftest reader drains the FIFO over a valid/ready port.
// - Also keeps cycle and instret counters and checks PC-chain continuity: commit_pre_pc must equal the previous commit_pc.
// PARAMETERS
// - XLEN     32  PC width; matches the `XLEN define.
// - DEPTH    16  FIFO entries; power of two, minimum 2.
// - CNT_W    64  width of the cycle, instret and drop counters.
// PORTS
// - clk            in   1         core clock
// - rst            in   1         synchronous, active-low reset
// - commit         in   1         one instruction retires this cycle
// - commit_pc      in   XLEN      PC of the retiring instruction
// - commit_pre_pc  in   XLEN      PC of the previously retired instruction, as reported by the WB stage
// - out_valid      out  1         FIFO head is valid
// - out_ready      in   1         reader accepts the head this cycle
// - out_pc         out  XLEN      head: commit_pc
// - out_pre_pc     out  XLEN      head: commit_pre_pc
// - out_seq        out  32        head: retirement sequence number, starting at 0
// - out_cycle      out  CNT_W     head: cycle_cnt value sampled at retirement
// - level          out  log2(DEPTH)+1  current occupancy
// - cycle_cnt      out  CNT_W     cycles since reset release
// - instret_cnt    out  CNT_W     commits observed, including dropped ones
// - drop_cnt       out  CNT_W     commits dropped because the FIFO was full
// - overflow       out  1         sticky: at least one commit was dropped
// - seq_err        out  1         sticky: PC-chain mismatch seen
// - err_pc         out  XLEN      commit_pc of the first mismatching commit
// - clear_err      in   1         clears overflow, seq_err and err_pc
// BEHAVIOUR
// - Reset (rst==0 at a clk edge):
//   - All counters, level, the pointers, overflow, seq_err and err_pc go to 0.
//   - out_valid goes to 0. Payload outputs go to 0.
//   - The have_last flag goes to 0.
//   - Any FIFO contents are discarded.
// - cycle_cnt increments every cycle that rst==1. instret_cnt increments on each commit. All counters wrap modulo 2^CNT_W.
// - Push: on commit with level<DEPTH, the entry {commit_pc, commit_pre_pc, seq=instret_cnt[31:0], cycle=cycle_cnt} is written.
//   - The entry is visible at the head no earlier than the next cycle. Latency is 1 cycle when the FIFO was empty.
// - Pop: out_valid && out_ready advances the head. out_* is driven straight from registered storage, with no combinational path from commit.
// - Full: commit with level==DEPTH and no simultaneous pop drops the entry. drop_cnt increments, overflow is set, instret_cnt still increments.
// - Full plus pop in the same cycle: both the pop and the push are accepted; level stays at DEPTH and nothing is dropped.
// - Empty plus push: no bypass; out_valid rises the next cycle. A pop request while out_valid==0 is ignored.
// - Pointers are log2(DEPTH) bits and wrap naturally. level is tracked separately so that full and empty are unambiguous.
// - Continuity check, active only when commit==1:
//   - If have_last==1 and commit_pre_pc != last_pc, seq_err is set. err_pc captures commit_pc, but only if seq_err was 0.
//   - last_pc takes commit_pc and have_last is set to 1. The first commit after reset is never checked.
//   - The check also runs on dropped commits.
// - clear_err clears the sticky flags next cycle. If a new error or drop occurs in the same cycle, the new event wins: the flag stays set and err_pc takes the new PC.
// - Reset asserted mid-stream: a commit or pop in that cycle is ignored.
// - This is a passive observer: it never back-pressures the cpu.
// STRUCTURE
// - cpu.vh gains `COMMIT_REC_WIDTH (2*XLEN+32+CNT_W) and the field-offset defines used to pack and unpack a record.
// - One sub-module, sync_fifo (WIDTH, DEPTH; push/pop/full/empty/level, synchronous active-low reset), reusable elsewhere.
// - The top level holds the counters, the continuity checker and the sticky error logic.
// TESTING
// 1. Reset then 3 commits with pc 0x1000/0x1004/0x1008 and pre_pc x/0x1000/0x1004, out_ready=1
//    -> 3 pops: seq 0,1,2; seq_err=0; instret_cnt=3.
// 2. out_ready=0 and 20 back-to-back commits, DEPTH=16
//    -> level=16; drop_cnt=4; overflow=1; instret_cnt=20; head seq=0.
// 3. Full FIFO, commit and out_ready=1 in the same cycle
//    -> level stays 16; drop_cnt is unchanged; the new entry appears at the tail.
// 4. pc 0x2000 then pc 0x2010 with pre_pc 0x1FFC
//    -> seq_err=1; err_pc=0x2010. A later mismatch leaves err_pc unchanged.
//    -> clear_err plus a simultaneous mismatch at 0x3000 gives seq_err=1 and err_pc=0x3000.
// 5. rst=0 for 1 cycle with 5 entries queued and commit=1
//    -> next cycle level=0, out_valid=0, cycle_cnt=0.
//    -> The following first commit is not continuity-checked.
// 6. Commit at cycle_cnt=10 into an empty FIFO
//    -> out_valid=1 at cycle 11; out_cycle=10.

Source files
------------

// File: rtl/commit_trace_buffer_pkg.sv
// Shared constants and record-layout helpers for the commit trace buffer.
// A record packs {pc, pre_pc, seq, cycle}, with cycle at the LSBs.
package commit_trace_buffer_pkg;

  localparam int SEQ_W = 32;

  function automatic int commit_rec_width(input int xlen, input int cnt_w);
    return 2 * xlen + SEQ_W + cnt_w;
  endfunction

  function automatic int off_seq(input int cnt_w);
    return cnt_w;
  endfunction

  function automatic int off_pre_pc(input int cnt_w);
    return cnt_w + SEQ_W;
  endfunction

  function automatic int off_pc(input int xlen, input int cnt_w);
    return cnt_w + SEQ_W + xlen;
  endfunction

endpackage

// File: rtl/commit_trace_buffer_sync_fifo.sv
// Generic synchronous FIFO with an explicit occupancy count.
// Read data comes straight from storage and reads as zero while empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push_ok, pop_ok;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    level_d = level_q;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/commit_trace_buffer.sv
// Retirement observer: stamps and queues each commit, keeps cycle/instret/drop
// counters and flags breaks in the commit_pre_pc -> commit_pc chain.
module commit_trace_buffer
  import commit_trace_buffer_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  parameter int CNT_W = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     commit,
  input  logic [XLEN-1:0]          commit_pc,
  input  logic [XLEN-1:0]          commit_pre_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_pre_pc,
  output logic [31:0]              out_seq,
  output logic [CNT_W-1:0]         out_cycle,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         cycle_cnt,
  output logic [CNT_W-1:0]         instret_cnt,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic                     overflow,
  output logic                     seq_err,
  output logic [XLEN-1:0]          err_pc,
  input  logic                     clear_err
);

  localparam int REC_W   = commit_rec_width(XLEN, CNT_W);
  localparam int O_SEQ   = off_seq(CNT_W);
  localparam int O_PRE   = off_pre_pc(CNT_W);
  localparam int O_PC    = off_pc(XLEN, CNT_W);

  logic [REC_W-1:0] wr_rec, rd_rec;
  logic             fifo_full, fifo_empty;
  logic             drop, chk_err;

  logic [CNT_W-1:0] cycle_q, instret_q, drop_q;
  logic             overflow_q, overflow_d;
  logic             seq_err_q, seq_err_d;
  logic [XLEN-1:0]  err_pc_q, err_pc_d;
  logic [XLEN-1:0]  last_pc_q;
  logic             have_last_q;

  assign wr_rec = {commit_pc, commit_pre_pc, instret_q[SEQ_W-1:0], cycle_q};

  sync_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (commit),
    .pop_i   (out_ready),
    .wdata_i (wr_rec),
    .rdata_o (rd_rec),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  assign out_valid  = !fifo_empty;
  assign out_pc     = rd_rec[O_PC +: XLEN];
  assign out_pre_pc = rd_rec[O_PRE +: XLEN];
  assign out_seq    = rd_rec[O_SEQ +: SEQ_W];
  assign out_cycle  = rd_rec[0 +: CNT_W];

  assign drop    = commit && fifo_full && !(out_ready && out_valid);
  assign chk_err = commit && have_last_q && (commit_pre_pc != last_pc_q);

  // A fresh event in the same cycle as clear_err takes priority over the clear.
  always_comb begin
    overflow_d = overflow_q;
    seq_err_d  = seq_err_q;
    err_pc_d   = err_pc_q;
    if (clear_err) begin
      overflow_d = 1'b0;
      seq_err_d  = 1'b0;
      err_pc_d   = '0;
    end
    if (drop) overflow_d = 1'b1;
    if (chk_err) begin
      seq_err_d = 1'b1;
      if (!seq_err_q || clear_err) err_pc_d = commit_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cycle_q     <= '0;
      instret_q   <= '0;
      drop_q      <= '0;
      overflow_q  <= 1'b0;
      seq_err_q   <= 1'b0;
      err_pc_q    <= '0;
      have_last_q <= 1'b0;
    end else begin
      cycle_q    <= cycle_q + CNT_W'(1);
      if (commit) instret_q <= instret_q + CNT_W'(1);
      if (drop)   drop_q    <= drop_q + CNT_W'(1);
      overflow_q <= overflow_d;
      seq_err_q  <= seq_err_d;
      err_pc_q   <= err_pc_d;
      if (commit) have_last_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && commit) last_pc_q <= commit_pc;
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
  assign drop_cnt    = drop_q;
  assign overflow    = overflow_q;
  assign seq_err     = seq_err_q;
  assign err_pc      = err_pc_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer with DEPTH=16, XLEN=32, CNT_W=64.
module tb_commit_trace_buffer;

  logic        clk;
  logic        rst;
  logic        commit;
  logic [31:0] commit_pc;
  logic [31:0] commit_pre_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_pre_pc;
  logic [31:0] out_seq;
  logic [63:0] out_cycle;
  logic [4:0]  level;
  logic [63:0] cycle_cnt;
  logic [63:0] instret_cnt;
  logic [63:0] drop_cnt;
  logic        overflow;
  logic        seq_err;
  logic [31:0] err_pc;
  logic        clear_err;

  int errors = 0;
  int checks = 0;

  commit_trace_buffer #(
    .XLEN  (32),
    .DEPTH (16),
    .CNT_W (64)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .commit        (commit),
    .commit_pc     (commit_pc),
    .commit_pre_pc (commit_pre_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_pre_pc    (out_pre_pc),
    .out_seq       (out_seq),
    .out_cycle     (out_cycle),
    .level         (level),
    .cycle_cnt     (cycle_cnt),
    .instret_cnt   (instret_cnt),
    .drop_cnt      (drop_cnt),
    .overflow      (overflow),
    .seq_err       (seq_err),
    .err_pc        (err_pc),
    .clear_err     (clear_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; commit = 1'b0; commit_pc = '0; commit_pre_pc = '0;
    out_ready = 1'b0; clear_err = 1'b0;
    tick();
    tick();
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_cycle", cycle_cnt, 64'd0);
    chk("rst_instret", instret_cnt, 64'd0);
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    chk("rst_seq_err", 64'(seq_err), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    rst = 1'b1;

    // Three chained commits drained as they arrive
    out_ready = 1'b1; commit = 1'b1;
    commit_pc = 32'h1000; commit_pre_pc = 32'hDEAD_BEEF;
    tick();
    chk("t1_valid0", 64'(out_valid), 64'd1);
    chk("t1_seq0", 64'(out_seq), 64'd0);
    chk("t1_pc0", 64'(out_pc), 64'h1000);
    chk("t1_cycle0", out_cycle, 64'd0);
    commit_pc = 32'h1004; commit_pre_pc = 32'h1000;
    tick();
    chk("t1_seq1", 64'(out_seq), 64'd1);
    chk("t1_level1", 64'(level), 64'd1);
    commit_pc = 32'h1008; commit_pre_pc = 32'h1004;
    tick();
    chk("t1_seq2", 64'(out_seq), 64'd2);
    chk("t1_pre2", 64'(out_pre_pc), 64'h1004);
    commit = 1'b0;
    tick();
    chk("t1_level_end", 64'(level), 64'd0);
    chk("t1_valid_end", 64'(out_valid), 64'd0);
    chk("t1_instret", instret_cnt, 64'd3);
    chk("t1_seq_err", 64'(seq_err), 64'd0);
    chk("t1_cycle", cycle_cnt, 64'd4);

    // Overfill with the reader stalled
    rst = 1'b0;
    tick();
    rst = 1'b1; out_ready = 1'b0; commit = 1'b1;
    for (int i = 0; i < 20; i++) begin
      commit_pc     = 32'h4000 + 32'(4 * i);
      commit_pre_pc = (i == 0) ? 32'h0 : 32'h4000 + 32'(4 * (i - 1));
      tick();
    end
    chk("t2_level", 64'(level), 64'd16);
    chk("t2_drop", drop_cnt, 64'd4);
    chk("t2_overflow", 64'(overflow), 64'd1);
    chk("t2_instret", instret_cnt, 64'd20);
    chk("t2_head_seq", 64'(out_seq), 64'd0);
    chk("t2_head_pc", 64'(out_pc), 64'h4000);
    chk("t2_seq_err", 64'(seq_err), 64'd0);

    // Full FIFO with simultaneous push and pop
    commit_pc = 32'h4050; commit_pre_pc = 32'h404C; out_ready = 1'b1;
    tick();
    commit = 1'b0;
    chk("t3_level", 64'(level), 64'd16);
    chk("t3_drop", drop_cnt, 64'd4);
    chk("t3_instret", instret_cnt, 64'd21);
    for (int j = 0; j < 16; j++) begin
      chk("t3_drain_seq", 64'(out_seq), (j < 15) ? 64'(j + 1) : 64'd20);
      if (j == 15) chk("t3_tail_pc", 64'(out_pc), 64'h4050);
      tick();
    end
    chk("t3_level_end", 64'(level), 64'd0);
    chk("t3_valid_end", 64'(out_valid), 64'd0);

    // PC-chain errors and clear priority
    commit = 1'b1; commit_pc = 32'h2000; commit_pre_pc = 32'h4050;
    tick();
    chk("t4_no_err", 64'(seq_err), 64'd0);
    commit_pc = 32'h2010; commit_pre_pc = 32'h1FFC;
    tick();
    chk("t4_seq_err", 64'(seq_err), 64'd1);
    chk("t4_err_pc", 64'(err_pc), 64'h2010);
    commit_pc = 32'h2020; commit_pre_pc = 32'h0;
    tick();
    chk("t4_err_pc_kept", 64'(err_pc), 64'h2010);
    clear_err = 1'b1; commit_pc = 32'h3000; commit_pre_pc = 32'h0;
    tick();
    chk("t4_clr_new_err", 64'(seq_err), 64'd1);
    chk("t4_clr_new_pc", 64'(err_pc), 64'h3000);
    chk("t4_clr_overflow", 64'(overflow), 64'd0);
    commit = 1'b0;
    tick();
    chk("t4_cleared", 64'(seq_err), 64'd0);
    chk("t4_err_pc_clr", 64'(err_pc), 64'd0);
    clear_err = 1'b0;

    // Reset mid-stream with entries queued and a commit pending
    out_ready = 1'b0; commit = 1'b1;
    for (int i = 0; i < 5; i++) begin
      commit_pc     = 32'h5000 + 32'(4 * i);
      commit_pre_pc = (i == 0) ? 32'h3000 : 32'h5000 + 32'(4 * (i - 1));
      tick();
    end
    commit = 1'b0;
    chk("t5_level_pre", 64'(level), 64'd5);
    rst = 1'b0; commit = 1'b1; out_ready = 1'b1;
    commit_pc = 32'h6000; commit_pre_pc = 32'h5010;
    tick();
    rst = 1'b1; commit = 1'b0; out_ready = 1'b0;
    chk("t5_level", 64'(level), 64'd0);
    chk("t5_valid", 64'(out_valid), 64'd0);
    chk("t5_cycle", cycle_cnt, 64'd0);
    chk("t5_instret", instret_cnt, 64'd0);
    chk("t5_drop", drop_cnt, 64'd0);
    chk("t5_out_pc", 64'(out_pc), 64'd0);

    // First commit after reset lands at cycle 10, unchecked for continuity
    repeat (10) tick();
    chk("t6_cycle_pre", cycle_cnt, 64'd10);
    chk("t6_valid_pre", 64'(out_valid), 64'd0);
    commit = 1'b1; commit_pc = 32'h7000; commit_pre_pc = 32'hBAD0;
    tick();
    commit = 1'b0;
    chk("t6_valid", 64'(out_valid), 64'd1);
    chk("t6_out_cycle", out_cycle, 64'd10);
    chk("t6_out_seq", 64'(out_seq), 64'd0);
    chk("t6_out_pc", 64'(out_pc), 64'h7000);
    chk("t6_seq_err", 64'(seq_err), 64'd0);
    chk("t6_cycle", cycle_cnt, 64'd11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
